// File: rtl/stream_minmax.sv
// Streaming signed min/max reducer: tracks running min/max, saturating count and overflow per frame.
// Define STREAM_MINMAX_ARGIDX_EN to build first-occurrence argmin/argmax tracking.
module stream_minmax #(
   parameter int unsigned N     = 32,
   parameter int unsigned IDX_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N-1:0]     out_min,
   output logic [N-1:0]     out_max,
   output logic [IDX_W-1:0] out_min_idx,
   output logic [IDX_W-1:0] out_max_idx,
   output logic [IDX_W-1:0] out_count,
   output logic             out_ovf
);

   localparam logic [IDX_W-1:0] CountMax = '1;

   typedef enum logic [1:0] {StFirst, StAcc, StDone} state_e;

   state_e           state_q, state_d;
   logic [N-1:0]     min_q, min_d, max_q, max_d;
   logic [IDX_W-1:0] count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             accept, drain, sat, lt_min, gt_max;

   // Handshake outputs are pure state decodes, forced low while reset is asserted.
   assign in_ready  = !rst && (state_q != StDone);
   assign out_valid = !rst && (state_q == StDone);
   assign accept    = in_valid && in_ready;
   assign drain     = out_valid && out_ready;
   assign sat       = (count_q == CountMax);

   // Strict signed compares: ties never replace, so the first occurrence wins.
   assign lt_min = $signed(in_data) < $signed(min_q);
   assign gt_max = $signed(max_q) < $signed(in_data);

   always_comb begin
      state_d = state_q;
      min_d   = min_q;
      max_d   = max_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         StFirst: begin
            if (accept) begin
               min_d   = in_data;
               max_d   = in_data;
               count_d = IDX_W'(1);
               ovf_d   = 1'b0;
               state_d = in_last ? StDone : StAcc;
            end
         end
         StAcc: begin
            if (accept) begin
               if (lt_min) min_d = in_data;
               if (gt_max) max_d = in_data;
               if (sat) ovf_d = 1'b1;
               else     count_d = count_q + IDX_W'(1);
               if (in_last) state_d = StDone;
            end
         end
         StDone: begin
            if (drain) state_d = StFirst;
         end
         default: state_d = StFirst;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StFirst;
         min_q   <= '0;
         max_q   <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         min_q   <= min_d;
         max_q   <= max_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   assign out_min   = rst ? '0 : min_q;
   assign out_max   = rst ? '0 : max_q;
   assign out_count = rst ? '0 : count_q;
   assign out_ovf   = !rst && ovf_q;

`ifdef STREAM_MINMAX_ARGIDX_EN
   logic [IDX_W-1:0] min_idx_q, min_idx_d, max_idx_q, max_idx_d;

   // Index of the current sample is the pre-increment count, which saturates with it.
   always_comb begin
      min_idx_d = min_idx_q;
      max_idx_d = max_idx_q;
      if (accept) begin
         if (state_q == StFirst) begin
            min_idx_d = '0;
            max_idx_d = '0;
         end else begin
            if (lt_min) min_idx_d = count_q;
            if (gt_max) max_idx_d = count_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         min_idx_q <= '0;
         max_idx_q <= '0;
      end else begin
         min_idx_q <= min_idx_d;
         max_idx_q <= max_idx_d;
      end
   end

   assign out_min_idx = rst ? '0 : min_idx_q;
   assign out_max_idx = rst ? '0 : max_idx_q;
`else
   assign out_min_idx = '0;
   assign out_max_idx = '0;
`endif

endmodule

// File: tb/tb_stream_minmax.sv
// Scoreboard bench for stream_minmax: frame-level reference model, randomized frames and
// consumer backpressure, plus directed signed/tie, saturation and mid-frame reset cases.
module tb_stream_minmax;

   localparam int N     = 32;
   localparam int IDX_W = 4;
   localparam int CMAX  = (1 << IDX_W) - 1;
   localparam int RW    = 2 * N + 3 * IDX_W + 1;

   typedef struct {
      logic [N-1:0]     mn;
      logic [N-1:0]     mx;
      logic [IDX_W-1:0] mni;
      logic [IDX_W-1:0] mxi;
      logic [IDX_W-1:0] cnt;
      logic             ovf;
   } res_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [N-1:0]     in_data;
   logic             in_last;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [N-1:0]     out_min;
   logic [N-1:0]     out_max;
   logic [IDX_W-1:0] out_min_idx;
   logic [IDX_W-1:0] out_max_idx;
   logic [IDX_W-1:0] out_count;
   logic             out_ovf;

   int   n_assert = 0;
   int   n_fail   = 0;
   res_t exp_q[$];
   int   frame_q[$];
   bit   bp_mode  = 1'b0;
   bit   bp_ready = 1'b0;
   logic [RW-1:0] prev_bus;
   bit   prev_hold = 1'b0;

   stream_minmax #(.N(N), .IDX_W(IDX_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .in_last     (in_last),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_min     (out_min),
      .out_max     (out_max),
      .out_min_idx (out_min_idx),
      .out_max_idx (out_max_idx),
      .out_count   (out_count),
      .out_ovf     (out_ovf)
   );

   always #5 clk = ~clk;

   // Consumer: random readiness unless a directed test owns out_ready.
   always @(posedge clk) begin
      #2;
      out_ready = bp_mode ? bp_ready : ($urandom_range(0, 3) != 0);
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [RW-1:0] res_bus();
      return {out_min, out_max, out_min_idx, out_max_idx, out_count, out_ovf};
   endfunction

   // Reference: whole-frame reduction from the stated rules.
   function automatic res_t model();
      res_t r;
      int mn, mx, mni, mxi, len;
      len = frame_q.size();
      mn = frame_q[0];
      mx = frame_q[0];
      mni = 0;
      mxi = 0;
      for (int i = 1; i < len; i++) begin
         if (frame_q[i] < mn) begin mn = frame_q[i]; mni = i; end
         if (frame_q[i] > mx) begin mx = frame_q[i]; mxi = i; end
      end
      r.mn  = mn;
      r.mx  = mx;
`ifdef STREAM_MINMAX_ARGIDX_EN
      r.mni = IDX_W'((mni > CMAX) ? CMAX : mni);
      r.mxi = IDX_W'((mxi > CMAX) ? CMAX : mxi);
`else
      r.mni = '0;
      r.mxi = '0;
`endif
      r.cnt = IDX_W'((len > CMAX) ? CMAX : len);
      r.ovf = (len > CMAX);
      return r;
   endfunction

   function automatic int rand_val();
      int sp[5] = '{0, -1, int'(32'h8000_0000), int'(32'h7FFF_FFFF), 5};
      case ($urandom_range(0, 4))
         0:       return int'($urandom);
         1:       return sp[$urandom_range(0, 4)];
         default: return int'($urandom_range(0, 15)) - 8;
      endcase
   endfunction

   // Monitor: compare every drained beat against the scoreboard; check holds under backpressure.
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (prev_hold) check("hold_stable", 128'(res_bus()), 128'(prev_bus));
         if (out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_beat", 128'(1), 128'(0));
            end else begin
               res_t e;
               e = exp_q.pop_front();
               check("min",     128'(out_min),     128'(e.mn));
               check("max",     128'(out_max),     128'(e.mx));
               check("min_idx", 128'(out_min_idx), 128'(e.mni));
               check("max_idx", 128'(out_max_idx), 128'(e.mxi));
               check("count",   128'(out_count),   128'(e.cnt));
               check("ovf",     128'(out_ovf),     128'(e.ovf));
            end
         end
      end
      prev_hold = !rst && out_valid && !out_ready;
      prev_bus  = res_bus();
   end

   // Entered and left at posedge+1. A frame without 'complete' never asserts in_last.
   task automatic send_frame(input bit complete);
      bit acc;
      int cyc;
      if (complete) exp_q.push_back(model());
      for (int k = 0; k < frame_q.size(); k++) begin
         if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 2)) @(posedge clk);
            #1;
         end
         in_valid = 1'b1;
         in_data  = frame_q[k];
         in_last  = complete && (k == frame_q.size() - 1);
         cyc = 0;
         do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            cyc++;
         end while (!acc && cyc < 200);
         if (!acc) begin
            check("accept_timeout", 128'(0), 128'(1));
            in_valid = 1'b0;
            in_last  = 1'b0;
            return;
         end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (complete) check("latency_out_valid", 128'(out_valid), 128'(1));
   endtask

   task automatic wait_drained();
      int cyc = 0;
      while (exp_q.size() != 0 && cyc < 2000) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      if (exp_q.size() != 0) check("drain_timeout", 128'(exp_q.size()), 128'(0));
   endtask

   task automatic check_idle(input string tag, input bit exp_ready);
      check({tag, "_in_ready"},  128'(in_ready),  128'(exp_ready));
      check({tag, "_out_valid"}, 128'(out_valid), 128'(0));
      check({tag, "_results"},   128'(res_bus()), 128'(0));
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      in_last  = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_idle("reset", 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_idle("post_reset", 1'b1);
      @(posedge clk);
      #1;

      frame_q = '{5};
      send_frame(1'b1);
      frame_q = '{3, -7, int'(32'h7FFF_FFFF), -7, int'(32'h8000_0000), int'(32'h7FFF_FFFF)};
      send_frame(1'b1);

      // Consumer stalls for 5 cycles after out_valid rises.
      wait_drained();
      bp_mode  = 1'b1;
      bp_ready = 1'b0;
      frame_q = '{10, -3, 7};
      send_frame(1'b1);
      repeat (5) begin
         @(negedge clk);
         check("bp_in_ready",  128'(in_ready),  128'(0));
         check("bp_out_valid", 128'(out_valid), 128'(1));
      end
      bp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      check("bp_after_drain_valid", 128'(out_valid), 128'(0));
      check("bp_after_drain_ready", 128'(in_ready),  128'(1));
      bp_mode = 1'b0;
      @(posedge clk);
      #1;

      frame_q = {};
      for (int i = 0; i < 20; i++) frame_q.push_back((i == 17) ? -1 : 100 + i);
      send_frame(1'b1);
      frame_q = '{2};
      send_frame(1'b1);

      // Reset in the middle of a frame discards it.
      wait_drained();
      frame_q = '{1, 2, 3};
      send_frame(1'b0);
      rst = 1'b1;
      @(negedge clk);
      check_idle("mid_reset", 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_idle("after_mid_reset", 1'b1);
      @(posedge clk);
      #1;
      frame_q = '{9, 4};
      send_frame(1'b1);

      for (int f = 0; f < 40; f++) begin
         frame_q = {};
         for (int i = 0; i < int'($urandom_range(1, 22)); i++) frame_q.push_back(rand_val());
         send_frame(1'b1);
      end

      wait_drained();
      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
